// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: fixed-priority sequencer that feeds the single RTC transaction engine.
// One registered transaction is in flight at a time, and a forced bus-turnaround gap follows it.
module rtc_bus_arbiter #(
  parameter int N_REQ   = 5,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_wr,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                txn_start,
  output logic                txn_wr,
  output logic [AW-1:0]       txn_addr,
  output logic [DW-1:0]       txn_wdata,
  input  logic                txn_done,
  input  logic [DW-1:0]       txn_rdata
);

  localparam int         IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t           state_r;
  logic [IW-1:0]    sel_r;
  logic [7:0]       tmo_cnt_r;
  logic [3:0]       gap_cnt_r;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] done_r;
  logic             err_r;
  logic [DW-1:0]    rdata_r;
  logic             busy_r;
  logic             txn_start_r;
  logic             txn_wr_r;
  logic [AW-1:0]    txn_addr_r;
  logic [DW-1:0]    txn_wdata_r;

  logic [IW-1:0]    pick_s;
  logic             pick_wr_s;
  logic [AW-1:0]    pick_addr_s;
  logic [DW-1:0]    pick_wdata_s;

  // Index 0 has the highest priority, so the lowest set bit wins.
  function automatic logic [IW-1:0] lowest_set(input logic [N_REQ-1:0] r);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = r[i] ? IW'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = {N_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Winner selection and operand mux for the requester that would be granted this cycle.
  always_comb begin
    pick_s       = lowest_set(req);
    pick_wr_s    = req_wr[pick_s];
    pick_addr_s  = req_addr[int'(pick_s) * AW +: AW];
    pick_wdata_s = req_wdata[int'(pick_s) * DW +: DW];
  end

  // Sequencer FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= {IW{1'b0}};
      tmo_cnt_r   <= 8'd0;
      gap_cnt_r   <= 4'd0;
      gnt_r       <= {N_REQ{1'b0}};
      done_r      <= {N_REQ{1'b0}};
      err_r       <= 1'b0;
      rdata_r     <= {DW{1'b0}};
      busy_r      <= 1'b0;
      txn_start_r <= 1'b0;
      txn_wr_r    <= 1'b0;
      txn_addr_r  <= {AW{1'b0}};
      txn_wdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            sel_r       <= pick_s;
            txn_wr_r    <= pick_wr_s;
            txn_addr_r  <= pick_addr_s;
            txn_wdata_r <= pick_wdata_s;
            txn_start_r <= 1'b1;
            gnt_r       <= to_onehot(pick_s);
            busy_r      <= 1'b1;
            tmo_cnt_r   <= 8'd0;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          txn_start_r <= 1'b0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the final permitted cycle still counts as success.
          if (txn_done) begin
            rdata_r <= txn_rdata;
            done_r  <= to_onehot(sel_r);
            err_r   <= 1'b0;
            state_r <= ST_DONE;
          end else if (tmo_cnt_r == TMO_LAST) begin
            rdata_r <= {DW{1'b0}};
            done_r  <= to_onehot(sel_r);
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          done_r    <= {N_REQ{1'b0}};
          err_r     <= 1'b0;
          gnt_r     <= {N_REQ{1'b0}};
          gap_cnt_r <= 4'd0;
          state_r   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= {N_REQ{1'b0}};
          done_r      <= {N_REQ{1'b0}};
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          txn_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign txn_start = txn_start_r;
  assign txn_wr    = txn_wr_r;
  assign txn_addr  = txn_addr_r;
  assign txn_wdata = txn_wdata_r;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: directed scenarios plus randomized request chains, checked against
// a transaction-level model built from the arbitration and latency rules.
module tb_rtc_bus_arbiter;

  localparam int N_REQ   = 5;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;
  localparam int GAP_CYC = 4;

  logic                clk = 1'b0;
  logic                Reset;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                err;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                txn_start;
  logic                txn_wr;
  logic [AW-1:0]       txn_addr;
  logic [DW-1:0]       txn_wdata;
  logic                txn_done;
  logic [DW-1:0]       txn_rdata;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] model_rdata;

  rtc_bus_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .Reset(Reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .txn_start(txn_start), .txn_wr(txn_wr), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_done(txn_done), .txn_rdata(txn_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_gnt"},   {27'd0, gnt},       32'd0);
    check({tag, "_done"},  {27'd0, done},      32'd0);
    check({tag, "_err"},   {31'd0, err},       32'd0);
    check({tag, "_start"}, {31'd0, txn_start}, 32'd0);
  endtask

  task automatic randomize_slots();
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom);
      req_wdata[i*DW +: DW] = DW'($urandom);
      req_wr[i]             = 1'($urandom);
    end
  endtask

  // Entered at the falling edge of an IDLE cycle with req already nonzero; returns at the
  // falling edge of the IDLE cycle that follows the gap. delay<0 means the engine never answers.
  task automatic do_txn(input int delay, input logic [DW-1:0] rd, input logic [N_REQ-1:0] late,
                        input bit drop, input bit stray_gap, input bit keep);
    logic [N_REQ-1:0] wmask;
    logic [AW-1:0]    ea;
    logic [DW-1:0]    ed;
    logic             ew;
    bit               answered;
    int               wi;
    wmask = req & (~req + 5'd1);
    wi = 0;
    for (int i = 0; i < N_REQ; i++) if (wmask[i]) wi = i;
    ea = req_addr[wi*AW +: AW];
    ed = req_wdata[wi*DW +: DW];
    ew = req_wr[wi];

    @(negedge clk);
    check("issue_start", {31'd0, txn_start}, 32'd1);
    check("issue_gnt",   {27'd0, gnt},       {27'd0, wmask});
    check("issue_addr",  {24'd0, txn_addr},  {24'd0, ea});
    check("issue_wdata", {24'd0, txn_wdata}, {24'd0, ed});
    check("issue_wr",    {31'd0, txn_wr},    {31'd0, ew});
    check("issue_busy",  {31'd0, busy},      32'd1);
    check("issue_done",  {27'd0, done},      32'd0);
    if (drop) req = req & ~wmask;

    answered = 1'b0;
    for (int k = 0; k < TIMEOUT && !answered; k++) begin
      @(negedge clk);
      check("wait_gnt",   {27'd0, gnt},       {27'd0, wmask});
      check("wait_start", {31'd0, txn_start}, 32'd0);
      check("wait_done",  {27'd0, done},      32'd0);
      check("wait_addr",  {24'd0, txn_addr},  {24'd0, ea});
      // Other requesters may change their operands while not granted.
      if (k == 0) begin
        for (int i = 0; i < N_REQ; i++) if (i != wi) req_addr[i*AW +: AW] = AW'($urandom);
      end
      if (k == 1) req = req | late;
      if (k == delay) begin
        txn_done  = 1'b1;
        txn_rdata = rd;
        answered  = 1'b1;
      end
    end
    model_rdata = answered ? rd : {DW{1'b0}};

    @(negedge clk);
    txn_done  = 1'b0;
    txn_rdata = DW'($urandom);
    check("done_pulse", {27'd0, done},     {27'd0, wmask});
    check("done_err",   {31'd0, err},      {31'd0, !answered});
    check("done_rdata", {24'd0, rdata},    {24'd0, model_rdata});
    check("done_gnt",   {27'd0, gnt},      {27'd0, wmask});
    check("done_addr",  {24'd0, txn_addr}, {24'd0, ea});
    check("done_busy",  {31'd0, busy},     32'd1);
    if (!keep) req = req & ~wmask;

    for (int g = 0; g < GAP_CYC; g++) begin
      @(negedge clk);
      check("gap_gnt",   {27'd0, gnt},      32'd0);
      check("gap_done",  {27'd0, done},     32'd0);
      check("gap_err",   {31'd0, err},      32'd0);
      check("gap_busy",  {31'd0, busy},     32'd1);
      check("gap_addr",  {24'd0, txn_addr}, {24'd0, ea});
      check("gap_rdata", {24'd0, rdata},    {24'd0, model_rdata});
      txn_done = stray_gap && (g == 1);
    end

    @(negedge clk);
    txn_done = 1'b0;
    check_quiet("idle");
    check("idle_rdata", {24'd0, rdata}, {24'd0, model_rdata});
  endtask

  initial begin
    int guard;
    Reset     = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    txn_done  = 1'b0;
    txn_rdata = '0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_rdata", {24'd0, rdata}, 32'd0);
    check("reset_addr",  {24'd0, txn_addr}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);

    // Single read from requester 4, engine answers 10 cycles after txn_start.
    randomize_slots();
    req_wr[4] = 1'b0;
    req_addr[4*AW +: AW] = 8'h21;
    req = 5'b10000;
    do_txn(9, 8'h59, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Write (3) and read (4) together: write first, read right after the gap.
    req_wr[3] = 1'b1;
    req_addr[3*AW +: AW]  = 8'h22;
    req_wdata[3*DW +: DW] = 8'h15;
    req = 5'b11000;
    do_txn(3, 8'h00, 5'b00000, 1'b0, 1'b0, 1'b0);
    do_txn(5, 8'h7e, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Requester 0 arriving during a read waits for it, then is granted.
    req = 5'b10000;
    do_txn(6, 8'h3c, 5'b00001, 1'b0, 1'b0, 1'b0);
    do_txn(0, 8'hc3, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Timeout abort, then the last-cycle success boundary, then minimum latency.
    req = 5'b00100;
    do_txn(-1, 8'hff, 5'b00000, 1'b0, 1'b0, 1'b0);
    req = 5'b00010;
    do_txn(TIMEOUT - 1, 8'h9a, 5'b00000, 1'b0, 1'b0, 1'b0);
    req = 5'b01000;
    do_txn(0, 8'h44, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Request dropped after issue still completes; stray txn_done in the gap is ignored.
    req = 5'b10000;
    do_txn(2, 8'h66, 5'b00000, 1'b1, 1'b1, 1'b0);

    // Stray txn_done while idle.
    txn_done  = 1'b1;
    txn_rdata = 8'ha5;
    @(negedge clk);
    txn_done = 1'b0;
    check_quiet("stray_idle");
    check("stray_idle_rdata", {24'd0, rdata}, {24'd0, model_rdata});

    // Reset in the middle of WAIT aborts silently.
    req = 5'b10000;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    req   = '0;
    @(negedge clk);
    Reset = 1'b0;
    check_quiet("midreset");
    check("midreset_rdata", {24'd0, rdata},     32'd0);
    check("midreset_addr",  {24'd0, txn_addr},  32'd0);
    check("midreset_wr",    {31'd0, txn_wr},    32'd0);
    check("midreset_wdata", {24'd0, txn_wdata}, 32'd0);
    model_rdata = '0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("post_reset");
    end
    req = 5'b10000;
    do_txn(4, 8'h12, 5'b00000, 1'b0, 1'b0, 1'b0);

    // Randomized request chains, each drained by fixed priority.
    for (int c = 0; c < 25; c++) begin
      randomize_slots();
      req = N_REQ'($urandom_range(1, 31));
      guard = 0;
      while (req != '0 && guard < 10) begin
        do_txn(($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 20)),
               DW'($urandom), 5'b00000, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
        guard++;
      end
      req = '0;
      @(negedge clk);
      check_quiet("chain_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
